// File: rtl/uart_rx_sched_if.sv
// FIFO-side bus of the UART receive scheduler.
// The master modport is the scheduler; the slave modport is the receive FIFO.
interface uart_rx_sched_if #(
  parameter int DWIDTH = 8
);
  logic              fifo_wr;
  logic [DWIDTH-1:0] fifo_wdata;
  logic              fifo_rd;
  logic [DWIDTH-1:0] fifo_rdata;
  logic              fifo_empty;
  logic              fifo_full;

  modport master (
    output fifo_wr,
    output fifo_wdata,
    output fifo_rd,
    input  fifo_rdata,
    input  fifo_empty,
    input  fifo_full
  );

  modport slave (
    input  fifo_wr,
    input  fifo_wdata,
    input  fifo_rd,
    output fifo_rdata,
    output fifo_empty,
    output fifo_full
  );
endinterface

// File: rtl/uart_rx_sched.sv
// UART receive scheduler: FIFO write path, head prefetch, CPU/DMA round-robin, level and irqs.
// Optional character timeout is built when UART_RX_SCHED_TIMEOUT_EN is defined.
module uart_rx_sched #(
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 4,
  parameter int TOWIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_valid,
  input  logic [DWIDTH-1:0]   rx_data,
  uart_rx_sched_if.master     fifo,
  input  logic                cpu_req,
  input  logic                dma_req,
  input  logic                dma_en,
  output logic                cpu_gnt,
  output logic                dma_gnt,
  output logic [DWIDTH-1:0]   rd_data,
  output logic                rd_valid,
  input  logic [AWIDTH+1:0]   trig_lvl,
  input  logic [TOWIDTH-1:0]  to_limit,
  input  logic                ovr_clr,
  output logic [AWIDTH+1:0]   level,
  output logic                irq_trig,
  output logic                irq_timeout,
  output logic                overrun
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_VALID = 1'b1
  } state_t;

  localparam logic [AWIDTH+1:0] LEVEL_MAX = (AWIDTH+2)'((2 ** AWIDTH) + 1);

  state_t              state_q, state_d;
  logic [DWIDTH-1:0]   rd_data_q, rd_data_d;
  logic [AWIDTH+1:0]   level_q, level_d;
  logic                overrun_q, overrun_d;
  logic                last_dma_q, last_dma_d;

  logic                wr_acc;
  logic                wr_drop;
  logic                cpu_elig;
  logic                dma_elig;
  logic                cpu_gnt_c;
  logic                dma_gnt_c;
  logic                gnt;
  logic                pop;

  assign fifo.fifo_wr    = rx_valid;
  assign fifo.fifo_wdata = rx_data;
  assign fifo.fifo_rd    = pop;

  assign wr_acc   = rx_valid & ~fifo.fifo_full;
  assign wr_drop  = rx_valid &  fifo.fifo_full;
  assign cpu_elig = cpu_req;
  assign dma_elig = dma_req & dma_en;

  // On a conflict the requester that did not win last time gets the byte.
  always_comb begin
    cpu_gnt_c = 1'b0;
    dma_gnt_c = 1'b0;
    if (state_q == S_VALID) begin
      if (cpu_elig && (!dma_elig || last_dma_q)) begin
        cpu_gnt_c = 1'b1;
      end else if (dma_elig) begin
        dma_gnt_c = 1'b1;
      end
    end
  end

  assign gnt = cpu_gnt_c | dma_gnt_c;

  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    pop       = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (!fifo.fifo_empty) begin
          pop       = 1'b1;
          rd_data_d = fifo.fifo_rdata;
          state_d   = S_VALID;
        end
      end
      S_VALID: begin
        if (gnt) begin
          if (!fifo.fifo_empty) begin
            pop       = 1'b1;
            rd_data_d = fifo.fifo_rdata;
          end else begin
            state_d = S_EMPTY;
          end
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  always_comb begin
    level_d    = level_q;
    overrun_d  = wr_drop | (overrun_q & ~ovr_clr);
    last_dma_d = last_dma_q;
    if (cpu_gnt_c) begin
      last_dma_d = 1'b0;
    end else if (dma_gnt_c) begin
      last_dma_d = 1'b1;
    end
    case ({wr_acc, gnt})
      2'b10: begin
        if (level_q != LEVEL_MAX) begin
          level_d = level_q + 1'b1;
        end
      end
      2'b01: begin
        if (level_q != '0) begin
          level_d = level_q - 1'b1;
        end
      end
      default: begin
        level_d = level_q;
      end
    endcase
  end

  // Last-grant pointer resets to DMA so the CPU wins the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      rd_data_q  <= '0;
      level_q    <= '0;
      overrun_q  <= 1'b0;
      last_dma_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      rd_data_q  <= rd_data_d;
      level_q    <= level_d;
      overrun_q  <= overrun_d;
      last_dma_q <= last_dma_d;
    end
  end

  assign cpu_gnt  = cpu_gnt_c;
  assign dma_gnt  = dma_gnt_c;
  assign rd_data  = rd_data_q;
  assign rd_valid = (state_q == S_VALID);
  assign level    = level_q;
  assign overrun  = overrun_q;
  assign irq_trig = (trig_lvl != '0) && (level_q >= trig_lvl);

`ifdef UART_RX_SCHED_TIMEOUT_EN
  logic [TOWIDTH-1:0] to_cnt_q, to_cnt_d;

  // Counts idle cycles while bytes are held; any traffic or an empty block restarts it.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((level_q == '0) || wr_acc || gnt) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != '1) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign irq_timeout = (to_limit != '0) && (to_cnt_q >= to_limit);
`else
  logic unused_to_limit;
  assign unused_to_limit = ^to_limit;
  assign irq_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sched.sv
// Directed testbench for uart_rx_sched with a behavioural 16-entry FIFO on the slave side.
module tb_uart_rx_sched;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TW = 16;

`ifdef UART_RX_SCHED_TIMEOUT_EN
  localparam logic TO_EXP = 1'b1;
`else
  localparam logic TO_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          cpu_req;
  logic          dma_req;
  logic          dma_en;
  logic          cpu_gnt;
  logic          dma_gnt;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW+1:0] trig_lvl;
  logic [TW-1:0] to_limit;
  logic          ovr_clr;
  logic [AW+1:0] level;
  logic          irq_trig;
  logic          irq_timeout;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_sched_if #(.DWIDTH(DW)) fif ();

  uart_rx_sched #(.DWIDTH(DW), .AWIDTH(AW), .TOWIDTH(TW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .fifo        (fif),
    .cpu_req     (cpu_req),
    .dma_req     (dma_req),
    .dma_en      (dma_en),
    .cpu_gnt     (cpu_gnt),
    .dma_gnt     (dma_gnt),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .trig_lvl    (trig_lvl),
    .to_limit    (to_limit),
    .ovr_clr     (ovr_clr),
    .level       (level),
    .irq_trig    (irq_trig),
    .irq_timeout (irq_timeout),
    .overrun     (overrun)
  );

  // Behavioural receive FIFO, reset by the same rst as the scheduler.
  logic [DW-1:0] mem [16];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          pop_empty_err;
  logic          push;
  logic          pop;

  assign fif.fifo_rdata = mem[rptr];
  assign fif.fifo_empty = (cnt == 0);
  assign fif.fifo_full  = (cnt == 16);
  assign push = fif.fifo_wr & ~fif.fifo_full;
  assign pop  = fif.fifo_rd & ~fif.fifo_empty;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      cnt           <= '0;
      pop_empty_err <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= fif.fifo_wdata;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (fif.fifo_rd && fif.fifo_empty) begin
        pop_empty_err <= 1'b1;
      end
      cnt <= cnt + {4'b0, push} - {4'b0, pop};
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  // One receive strobe; returns one cycle later, after the write edge.
  task automatic applyStimulus(input logic [DW-1:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    nextCycle();
    rx_valid = 1'b0;
  endtask

  task automatic waitGrant(input string tag, input logic exp_dma, input logic [DW-1:0] exp_data);
    int n = 0;
    #1;
    while (!(cpu_gnt || dma_gnt) && n < 20) begin
      nextCycle();
      n++;
    end
    checkOutput({tag, " seen"}, 32'(cpu_gnt | dma_gnt), 32'd1);
    if (cpu_gnt || dma_gnt) begin
      checkOutput({tag, " who"}, 32'({cpu_gnt, dma_gnt}), exp_dma ? 32'd1 : 32'd2);
      checkOutput({tag, " data"}, 32'(rd_data), 32'(exp_data));
    end
    nextCycle();
  endtask

  task automatic resetDut();
    rst      = 1'b1;
    rx_valid = 1'b0;
    cpu_req  = 1'b0;
    dma_req  = 1'b0;
    ovr_clr  = 1'b0;
    nextCycle();
    rst = 1'b0;
    nextCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rx_valid = 1'b0;
    rx_data  = '0;
    cpu_req  = 1'b0;
    dma_req  = 1'b0;
    dma_en   = 1'b0;
    trig_lvl = '0;
    to_limit = '0;
    ovr_clr  = 1'b0;
    nextCycle();
    checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("reset rd_data", 32'(rd_data), 32'd0);
    checkOutput("reset level", 32'(level), 32'd0);
    checkOutput("reset overrun", 32'(overrun), 32'd0);
    checkOutput("reset irq_trig", 32'(irq_trig), 32'd0);
    checkOutput("reset irq_timeout", 32'(irq_timeout), 32'd0);
    checkOutput("reset cpu_gnt", 32'(cpu_gnt), 32'd0);
    rst = 1'b0;
    nextCycle();

    // Three bytes streamed to a CPU that is already requesting.
    cpu_req = 1'b1;
    fork
      begin
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
      end
      begin
        waitGrant("cpu stream 0", 1'b0, 8'h11);
        waitGrant("cpu stream 1", 1'b0, 8'h22);
        waitGrant("cpu stream 2", 1'b0, 8'h33);
      end
    join
    cpu_req = 1'b0;
    #1;
    checkOutput("stream level", 32'(level), 32'd0);
    checkOutput("stream rd_valid", 32'(rd_valid), 32'd0);

    // Fill FIFO plus holding register, then overflow twice.
    resetDut();
    for (int k = 0; k < 17; k++) begin
      applyStimulus(8'(8'h40 + k));
    end
    checkOutput("full level", 32'(level), 32'd17);
    checkOutput("full overrun", 32'(overrun), 32'd0);
    checkOutput("full rd_valid", 32'(rd_valid), 32'd1);
    applyStimulus(8'hEE);
    checkOutput("drop overrun", 32'(overrun), 32'd1);
    checkOutput("drop level", 32'(level), 32'd17);
    ovr_clr = 1'b1;
    applyStimulus(8'hEF);
    ovr_clr = 1'b0;
    checkOutput("set beats clear", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    nextCycle();
    ovr_clr = 1'b0;
    checkOutput("ovr_clr", 32'(overrun), 32'd0);
    cpu_req = 1'b1;
    for (int k = 0; k < 17; k++) begin
      waitGrant("drain", 1'b0, 8'(8'h40 + k));
    end
    cpu_req = 1'b0;
    #1;
    checkOutput("drain level", 32'(level), 32'd0);
    checkOutput("drain rd_valid", 32'(rd_valid), 32'd0);

    // Round-robin with both requesters, then DMA disabled.
    resetDut();
    dma_en = 1'b1;
    applyStimulus(8'hA1);
    applyStimulus(8'hA2);
    applyStimulus(8'hA3);
    applyStimulus(8'hA4);
    nextCycle();
    cpu_req = 1'b1;
    dma_req = 1'b1;
    waitGrant("rr 0", 1'b0, 8'hA1);
    waitGrant("rr 1", 1'b1, 8'hA2);
    waitGrant("rr 2", 1'b0, 8'hA3);
    waitGrant("rr 3", 1'b1, 8'hA4);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    dma_en  = 1'b0;
    applyStimulus(8'hB1);
    applyStimulus(8'hB2);
    applyStimulus(8'hB3);
    applyStimulus(8'hB4);
    nextCycle();
    cpu_req = 1'b1;
    dma_req = 1'b1;
    waitGrant("dma off 0", 1'b0, 8'hB1);
    waitGrant("dma off 1", 1'b0, 8'hB2);
    waitGrant("dma off 2", 1'b0, 8'hB3);
    waitGrant("dma off 3", 1'b0, 8'hB4);
    cpu_req = 1'b0;
    dma_req = 1'b0;

    // Trigger level at 4 bytes.
    resetDut();
    trig_lvl = 6'd4;
    applyStimulus(8'h71);
    applyStimulus(8'h72);
    applyStimulus(8'h73);
    checkOutput("trig below", 32'(irq_trig), 32'd0);
    applyStimulus(8'h74);
    checkOutput("trig at 4", 32'(irq_trig), 32'd1);
    cpu_req = 1'b1;
    #1;
    checkOutput("trig grant", 32'(cpu_gnt), 32'd1);
    checkOutput("trig grant data", 32'(rd_data), 32'h71);
    nextCycle();
    cpu_req = 1'b0;
    #1;
    checkOutput("trig level 3", 32'(level), 32'd3);
    checkOutput("trig falls", 32'(irq_trig), 32'd0);
    trig_lvl = '0;

    // Character timeout after 10 idle cycles.
    resetDut();
    to_limit = 16'd10;
    applyStimulus(8'h55);
    for (int i = 1; i <= 10; i++) begin
      nextCycle();
      if (i == 9) checkOutput("timeout idle 9", 32'(irq_timeout), 32'd0);
      if (i == 10) checkOutput("timeout idle 10", 32'(irq_timeout), 32'(TO_EXP));
    end
    cpu_req = 1'b1;
    #1;
    checkOutput("timeout grant", 32'(cpu_gnt), 32'd1);
    nextCycle();
    cpu_req = 1'b0;
    #1;
    checkOutput("timeout cleared", 32'(irq_timeout), 32'd0);
    to_limit = '0;

    // Simultaneous write and grant, then reset in the middle of traffic.
    resetDut();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(8'(8'h80 + k));
    end
    checkOutput("level 5", 32'(level), 32'd5);
    rx_valid = 1'b1;
    rx_data  = 8'h85;
    cpu_req  = 1'b1;
    #1;
    checkOutput("wr+gnt grant", 32'(cpu_gnt), 32'd1);
    nextCycle();
    rx_valid = 1'b0;
    cpu_req  = 1'b0;
    #1;
    checkOutput("wr+gnt level", 32'(level), 32'd5);
    cpu_req = 1'b1;
    applyStimulus(8'h86);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("midrst rd_data", 32'(rd_data), 32'd0);
    checkOutput("midrst level", 32'(level), 32'd0);
    checkOutput("midrst overrun", 32'(overrun), 32'd0);
    checkOutput("midrst irq_trig", 32'(irq_trig), 32'd0);
    checkOutput("midrst irq_timeout", 32'(irq_timeout), 32'd0);
    checkOutput("midrst cpu_gnt", 32'(cpu_gnt), 32'd0);
    cpu_req = 1'b0;
    nextCycle();
    rst = 1'b0;
    nextCycle();

    checkOutput("no pop on empty", 32'(pop_empty_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_sched.md
# uart_rx_sched

Receive-side controller that sits between the UART receiver and the receive FIFO. It writes received bytes into the FIFO, prefetches the FIFO head into an output holding register, and shares that register between two consumers: CPU and DMA. Arbitration between them is round-robin. The block also tracks total occupancy and raises trigger-level, character-timeout and overrun indications for the interrupt logic.

## Interface
Parameters:
- `DWIDTH`, 8, data width; must match the FIFO.
- `AWIDTH`, 4, FIFO address width; FIFO depth is 2**AWIDTH.
- `TOWIDTH`, 16, width of the timeout counter and of `to_limit`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe: receiver has a byte.
- `rx_data`  in  DWIDTH  received byte.
- `fifo_wr`  out  1  FIFO write strobe.
- `fifo_wdata`  out  DWIDTH  FIFO write data.
- `fifo_rd`  out  1  FIFO pop strobe.
- `fifo_rdata`  in  DWIDTH  FIFO head data; combinational, valid whenever not empty.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_full`  in  1  FIFO full flag.
- `cpu_req`  in  1  CPU read request; level-sensitive.
- `dma_req`  in  1  DMA read request; level-sensitive.
- `dma_en`  in  1  when 0, `dma_req` is ignored.
- `cpu_gnt`  out  1  one-cycle grant to the CPU; `rd_data` is valid in this cycle.
- `dma_gnt`  out  1  one-cycle grant to the DMA.
- `rd_data`  out  DWIDTH  holding-register contents.
- `rd_valid`  out  1  holding register is full.
- `trig_lvl`  in  AWIDTH+2  interrupt trigger threshold; 0 disables the trigger interrupt.
- `to_limit`  in  TOWIDTH  idle cycles before timeout; 0 disables the timeout.
- `ovr_clr`  in  1  clears the overrun flag.
- `level`  out  AWIDTH+2  bytes held: FIFO occupancy plus the holding register.
- `irq_trig`  out  1  asserted while `level >= trig_lvl` and `trig_lvl != 0`; combinational from registered values.
- `irq_timeout`  out  1  character-timeout indication.
- `overrun`  out  1  sticky overrun flag.

## Operation
- Write path:
  - `fifo_wr = rx_valid`, `fifo_wdata = rx_data`, both combinational.
  - A write is accepted when `rx_valid & ~fifo_full`.
  - `rx_valid & fifo_full` drops the byte and sets `overrun` on the next edge.
  - `ovr_clr` clears `overrun`. If the set and clear conditions occur in the same cycle, set wins.
- Holding-register state machine:
  - S_EMPTY: `rd_valid=0`. If `~fifo_empty`, then `fifo_rd=1`, `fifo_rdata` is latched into `rd_data`, and the next state is S_VALID.
  - S_VALID: `rd_valid=1`. On a grant:
    - if `~fifo_empty`: `fifo_rd=1`, the head is latched, and the state stays S_VALID (back-to-back, one byte per cycle);
    - otherwise the next state is S_EMPTY.
  - With no grant, the state and `rd_data` hold.
- `fifo_rd` is never asserted while `fifo_empty=1`. A pop and an accepted write may occur in the same cycle.
- Arbitration:
  - Eligible requesters: `cpu_req`, and `dma_req & dma_en`.
  - Grants are issued only in S_VALID, at most one per cycle, combinational from the requests and registered state.
  - If only one requester is eligible, it is granted.
  - If both are eligible, the requester not granted last is granted. The last-grant pointer updates on every grant and resets to "DMA", so the CPU wins the first conflict.
- Level accounting:
  - `level` increments on an accepted write and decrements on a grant.
  - On both in the same cycle, it is unchanged.
  - Range is 0..2**AWIDTH+1, with no wrap.
- Timeout (when compiled in):
  - The counter clears whenever `level==0`, a write is accepted, or a grant occurs. Otherwise it increments, saturating at all-ones.
  - `irq_timeout=1` when `to_limit!=0` and the counter is >= `to_limit`.
  - It stays asserted until one of the clearing events occurs.

## Timing
- Reset values: `rd_valid=0`, `rd_data=0`, state S_EMPTY, `level=0`, `overrun=0`, `irq_timeout=0`, `irq_trig=0`, the timeout counter 0 and the last-grant pointer "DMA".
  - `fifo_wr` and `fifo_rd` are 0 whenever their driving inputs are low; `cpu_gnt` and `dma_gnt` are 0 while `rd_valid=0`.
  - Reset asserted mid-transfer discards the holding register immediately. The FIFO is reset by the same `rst`.
- Latency:
  - A byte written at edge N appears in the FIFO after edge N.
  - It is popped in cycle N+1 if the holding register is empty, giving `rd_valid=1` after edge N+1.
  - `rx_valid` to `rd_valid`: 2 cycles.
- The grant is a pulse in the same cycle as the request; the requester samples `rd_data` in that cycle.
- Throughput: one byte per cycle to alternating or single requesters.

## Configuration
- `UART_RX_SCHED_TIMEOUT_EN` defined: timeout counter and `irq_timeout` are present as described.
- Not defined: no counter is built, `irq_timeout` is tied to 0, and `to_limit` is unused.

## Test plan
- Reset, then 3 `rx_valid` bytes 0x11, 0x22, 0x33 with `cpu_req` held high -> `cpu_gnt` pulses with `rd_data` 0x11, 0x22, 0x33 in order; `level` returns to 0.
- Fill 2**AWIDTH+1 bytes with no requests, then one more byte -> `level=17` (AWIDTH=4), `overrun=1`, and the dropped byte never appears; `ovr_clr` -> `overrun=0`.
- `cpu_req` and `dma_req` held high with `dma_en=1` and 4 bytes queued -> grants go CPU, DMA, CPU, DMA. With `dma_en=0` -> all four go to the CPU.
- `trig_lvl=4`, write 4 bytes -> `irq_trig` rises after the 4th write; one grant -> `irq_trig` falls.
- `to_limit=10`, write 1 byte, no requests -> `irq_timeout` rises 10 idle cycles after the write; one grant -> it clears. Repeat without `UART_RX_SCHED_TIMEOUT_EN` -> `irq_timeout` stays 0.
- Simultaneous accepted write and grant with `level=5` -> `level` stays 5; assert `rst` mid-stream -> all outputs return to their reset values.
